lelbc_key_sched_ctrl: RTL
=========================

Name: lelbc_key_sched_ctrl

Overview:
Sequencer for the LELBC 128-bit key-update datapath. It loads a master key and iterates the key-update round function once per accepted round key. It streams round keys k0..k(ROUNDS-1) to the cipher round logic over a valid/ready handshake. It sits between the key input interface and the encryption round controller, and owns the 5-bit round counter that drives the update function.

Parameters:
ROUNDS, 31, number of round keys emitted per run; legal range 1..31 (the round counter is 5 bits).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a schedule; sampled only in IDLE
key_in  in  [0:127]  master key; bit 0 is MSB; captured on the accepted start
abort  in  1  synchronous cancel; returns to IDLE and suppresses done
rk_out  out  [0:127]  current round key
rk_idx  out  [0:4]  index of rk_out (0..ROUNDS-1)
rk_valid  out  1  rk_out/rk_idx are valid
rk_ready  in  1  consumer accepts the round key when rk_valid and rk_ready are both high
busy  out  1  high in EMIT and DONE
done  out  1  one-cycle pulse after the final round key is accepted

Behaviour:
- Update function U(k,c), MSB-first indexing:
  - t1 = k with k[124:127] replaced by S(k[124:127]); S = C,E,6,A,4,F,2,7,9,8,3,B,0,D,1,5 for inputs 0..F.
  - t2 = t1 with t1[121:124] XOR c[1:4]. c[0] is unused.
  - U = {t2[73:127], t2[64:72], t2[15:63], t2[0:14]}.
  - U is purely combinational inside this block and has no pipeline register.
- Key sequence: k0 = key_in; ki = U(k(i-1), i), where i is the 5-bit round counter value.
- States: IDLE, EMIT, DONE. The state machine is a registered FSM.
- Reset (asynchronous):
  - state=IDLE; key_reg=0; idx=0.
  - Outputs rk_out=0, rk_idx=0, rk_valid=0, busy=0, done=0.
  - Reset mid-run discards all progress; no done pulse is issued.
- IDLE:
  - rk_valid=0.
  - start=1 (with abort=0): key_reg<=key_in, idx<=0, go to EMIT. The first rk_valid appears 1 cycle after start.
- EMIT:
  - rk_valid=1; rk_out=key_reg; rk_idx=idx.
  - rk_out and rk_idx hold stable while rk_ready=0. The stall length is unbounded.
  - Handshake with idx<ROUNDS-1: key_reg<=U(key_reg, idx+1), idx<=idx+1, stay in EMIT. With continuous ready, throughput is 1 key per cycle.
  - Handshake with idx==ROUNDS-1: go to DONE.
- DONE:
  - done=1 for exactly one cycle, rk_valid=0; then go to IDLE.
  - rk_out and rk_idx keep the last key and index until the next start.
- start outside IDLE is ignored; no queuing.
- abort=1 in any state: next state is IDLE, rk_valid=0, no done pulse.
  - abort has priority over the handshake and over start in the same cycle.
  - key_reg and idx are left unchanged.
- ROUNDS=1: one key (k0) is emitted, then DONE.
- The round counter never wraps, because ROUNDS ≤ 31 keeps idx+1 ≤ 31.
- Latency from start to done with rk_ready held high: ROUNDS+1 cycles.

Test Plan:
1. Reset asserted mid-EMIT, asynchronously between clock edges: all outputs go to 0 immediately. After release, the next start with key_in=0 emits rk_idx=0, rk_out=0.
2. key_in=0, rk_ready=1, ROUNDS=31:
   - Key 0 is 0x0.
   - Key 1 is 0x00000000_00000800_00000000_00000000.
   - Keys 2..30 match a reference-model U chain.
   - done pulses exactly 1 cycle after the idx=30 handshake; total is 32 cycles from start.
3. Random rk_ready with 0-5 cycle stalls: rk_out and rk_idx are stable while stalled. The sequence is identical to test 2, and no key is duplicated or skipped.
4. start pulsed during EMIT at idx=5: it is ignored, and the sequence continues to idx=30 unchanged.
5. abort at idx=10 in the same cycle as a handshake:
   - Next cycle is IDLE with rk_valid=0 and no done pulse.
   - A new start with key_in=all-ones restarts at idx=0 with rk_out=all-ones.
6. ROUNDS=1 build: start -> one key (idx 0 = key_in) -> done 1 cycle after the handshake -> IDLE.

Source files
------------

// File: rtl/lelbc_key_sched_ctrl_if.sv
// Round-key stream bundle between the key scheduler (master) and the cipher round logic (slave).
// Also carries the start/abort control and the master key.
interface lelbc_key_sched_ctrl_if;
  logic           start;
  logic [0:127]   key_in;
  logic           abort;
  logic [0:127]   rk_out;
  logic [0:4]     rk_idx;
  logic           rk_valid;
  logic           rk_ready;
  logic           busy;
  logic           done;

  modport master (
    input  start, key_in, abort, rk_ready,
    output rk_out, rk_idx, rk_valid, busy, done
  );

  modport slave (
    output start, key_in, abort, rk_ready,
    input  rk_out, rk_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/lelbc_key_sched_ctrl.sv
// LELBC key-schedule sequencer: loads a master key and streams ROUNDS round keys, applying the
// combinational key-update function once per accepted key.
module lelbc_key_sched_ctrl #(
  parameter int unsigned ROUNDS = 31
) (
  input logic                   clk,
  input logic                   rst,
  lelbc_key_sched_ctrl_if.master ks_if
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  localparam logic [0:4] LastIdx = 5'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [0:4]   idx_q, idx_d;
  logic [0:4]   idx_inc;
  logic [0:127] key_upd;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'hE;
      4'h2: y = 4'h6;
      4'h3: y = 4'hA;
      4'h4: y = 4'h4;
      4'h5: y = 4'hF;
      4'h6: y = 4'h2;
      4'h7: y = 4'h7;
      4'h8: y = 4'h9;
      4'h9: y = 4'h8;
      4'hA: y = 4'h3;
      4'hB: y = 4'hB;
      4'hC: y = 4'h0;
      4'hD: y = 4'hD;
      4'hE: y = 4'h1;
      default: y = 4'h5;
    endcase
    return y;
  endfunction

  // Only the low four counter bits enter the update; the counter MSB is never mixed in.
  function automatic logic [0:127] key_update(input logic [0:127] k, input logic [0:3] c);
    logic [0:127] t;
    t = k;
    t[124:127] = sbox(k[124:127]);
    t[121:124] = t[121:124] ^ c;
    return {t[73:127], t[64:72], t[15:63], t[0:14]};
  endfunction

  assign idx_inc = idx_q + 5'd1;
  assign key_upd = key_update(key_q, idx_inc[1:4]);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (ks_if.start) begin
          key_d   = ks_if.key_in;
          idx_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (ks_if.rk_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            key_d = key_upd;
            idx_d = idx_inc;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over start and handshake but keeps the last key/index visible.
    if (ks_if.abort) begin
      state_d = StIdle;
      key_d   = key_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  assign ks_if.rk_out   = key_q;
  assign ks_if.rk_idx   = idx_q;
  assign ks_if.rk_valid = (state_q == StEmit);
  assign ks_if.busy     = (state_q == StEmit) || (state_q == StDone);
  assign ks_if.done     = (state_q == StDone);

endmodule
